// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RISC-V pipeline: load-use stalls, branch flushes,
// E-stage forwarding selects and sequencing of multi-cycle mul/div operations.
module hazard_ctrl_unit #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = $clog2(LATENCY) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       LoadE,
  input  logic       PCSrcE,
  input  logic       MdStartE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       StallE,
  output logic       FlushE,
  output logic       FlushM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MdDoneE
);

  typedef enum logic {IDLE, BUSY} state_t;

  // The start cycle itself is one of the LATENCY cycles and the done cycle another.
  localparam logic [CNT_W-1:0] LOAD_CNT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  state_t           state, nextState;
  logic [CNT_W-1:0] cnt, nextCnt;
  logic             lwStall;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; combinational blocks below use blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  assign lwStall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // NOTE: every output and next-state signal gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    StallE    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    MdDoneE   = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;

    // M-stage results are younger than W-stage ones, so M wins; x0 is never forwarded.
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;

    case (state)
      IDLE: begin
        if (MdStartE) begin
          if (LATENCY > 1) begin
            StallF    = 1'b1;
            StallD    = 1'b1;
            StallE    = 1'b1;
            FlushM    = 1'b1;
            nextState = BUSY;
            nextCnt   = LOAD_CNT;
          end else begin
            MdDoneE = 1'b1;
          end
        end else begin
          StallF = lwStall && !PCSrcE;
          StallD = lwStall && !PCSrcE;
          FlushD = PCSrcE;
          FlushE = lwStall || PCSrcE;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          StallF  = 1'b1;
          StallD  = 1'b1;
          StallE  = 1'b1;
          FlushM  = 1'b1;
          nextCnt = cnt - CNT_W'(1);
        end else begin
          MdDoneE   = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase

    // Reset silences every output immediately, without waiting for a clock edge.
    if (rst) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b0;
      StallE    = 1'b0;
      FlushE    = 1'b0;
      FlushM    = 1'b0;
      MdDoneE   = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: a LATENCY=4 and a LATENCY=1 instance share inputs;
// table-driven combinational vectors plus mul/div and reset sequences.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MdStartE;

  logic       StallF4, StallD4, FlushD4, StallE4, FlushE4, FlushM4, MdDoneE4;
  logic [1:0] ForwardAE4, ForwardBE4;
  logic       StallF1, StallD1, FlushD1, StallE1, FlushE1, FlushM1, MdDoneE1;
  logic [1:0] ForwardAE1, ForwardBE1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
    .StallF(StallF4), .StallD(StallD4), .FlushD(FlushD4), .StallE(StallE4),
    .FlushE(FlushE4), .FlushM(FlushM4), .ForwardAE(ForwardAE4), .ForwardBE(ForwardBE4),
    .MdDoneE(MdDoneE4)
  );

  hazard_ctrl_unit #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
    .StallF(StallF1), .StallD(StallD1), .FlushD(FlushD1), .StallE(StallE1),
    .FlushE(FlushE1), .FlushM(FlushM1), .ForwardAE(ForwardAE1), .ForwardBE(ForwardBE1),
    .MdDoneE(MdDoneE1)
  );

  // Output vector order: StallF StallD FlushD StallE FlushE FlushM ForwardAE ForwardBE MdDoneE
  logic [10:0] out4, out1;
  assign out4 = {StallF4, StallD4, FlushD4, StallE4, FlushE4, FlushM4, ForwardAE4, ForwardBE4, MdDoneE4};
  assign out1 = {StallF1, StallD1, FlushD1, StallE1, FlushE1, FlushM1, ForwardAE1, ForwardBE1, MdDoneE1};

  localparam logic [10:0] E_NONE  = 11'b0;
  localparam logic [10:0] E_LU    = {6'b110010, 2'b00, 2'b00, 1'b0};
  localparam logic [10:0] E_BR    = {6'b001010, 2'b00, 2'b00, 1'b0};
  localparam logic [10:0] E_MDSTL = {6'b110101, 2'b00, 2'b00, 1'b0};
  localparam logic [10:0] E_DONE  = {6'b000000, 2'b00, 2'b00, 1'b1};

  typedef struct packed {
    logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic        regWriteM, regWriteW, loadE, pcSrcE;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven there.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, LoadE, PCSrcE, MdStartE} = '0;
  endtask

  task automatic apply_vec(input vec_t v);
    Rs1D = v.rs1D; Rs2D = v.rs2D; Rs1E = v.rs1E; Rs2E = v.rs2E;
    RdE = v.rdE; RdM = v.rdM; RdW = v.rdW;
    RegWriteM = v.regWriteM; RegWriteW = v.regWriteW;
    LoadE = v.loadE; PCSrcE = v.pcSrcE; MdStartE = 1'b0;
  endtask

  // Hazard inputs that would flush/stall if the FSM were idle.
  task automatic drive_hazards();
    PCSrcE = 1'b1; LoadE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
  endtask

  initial begin
    //          rs1D  rs2D  rs1E  rs2E  rdE   rdM   rdW  rwM rwW ld pc  expected
    vecs[0]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 0, 0, 1, 0, E_LU};
    vecs[1]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 0, 0, 0, 0, E_NONE};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, E_NONE};
    vecs[3]  = '{5'd3, 5'd6, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 0, 0, 1, 0, E_LU};
    vecs[4]  = '{5'd3, 5'd4, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 0, 0, 1, 0, E_NONE};
    vecs[5]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 0, 0, 1, 1, E_BR};
    vecs[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, E_BR};
    vecs[7]  = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd7, 1, 1, 0, 0, {6'b0, 2'b10, 2'b00, 1'b0}};
    vecs[8]  = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 1, 1, 0, 0, {6'b0, 2'b01, 2'b00, 1'b0}};
    vecs[9]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd9, 5'd9, 1, 1, 0, 0, {6'b0, 2'b00, 2'b10, 1'b0}};
    vecs[10] = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd9, 5'd9, 0, 1, 0, 0, {6'b0, 2'b00, 2'b01, 1'b0}};
    vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, E_NONE};
    vecs[12] = '{5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 0, 0, 0, 0, E_NONE};
    vecs[13] = '{5'd5, 5'd0, 5'd7, 5'd7, 5'd5, 5'd7, 5'd0, 1, 0, 1, 0, {6'b110010, 2'b10, 2'b10, 1'b0}};

    // Reset overrides inputs that would otherwise assert outputs.
    clear_inputs();
    rst = 1'b1;
    drive_hazards();
    RegWriteM = 1'b1; RdM = 5'd7; Rs1E = 5'd7;
    #2;
    check("reset_quiet_l4", out4, E_NONE);
    check("reset_quiet_l1", out1, E_NONE);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();

    for (int i = 0; i < 14; i++) begin
      next_cycle();
      apply_vec(vecs[i]);
      #1;
      check($sformatf("vec%0d_l4", i), out4, vecs[i].exp);
      check($sformatf("vec%0d_l1", i), out1, vecs[i].exp);
    end

    // Single mul/div, LATENCY=4; hazards during cycles 1..3 must be ignored.
    next_cycle(); clear_inputs(); MdStartE = 1'b1; #1;
    check("md_c0", out4, E_MDSTL);
    check("md_l1_done", out1, E_DONE);
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); clear_inputs(); drive_hazards(); #1;
      check($sformatf("md_c%0d", c), out4, (c == 3) ? E_DONE : E_MDSTL);
    end
    next_cycle(); clear_inputs(); PCSrcE = 1'b1; #1;
    check("md_c4_idle", out4, E_BR);

    // Back-to-back mul/div with MdStartE held high.
    for (int c = 0; c < 8; c++) begin
      next_cycle(); clear_inputs(); MdStartE = 1'b1; #1;
      check($sformatf("b2b_c%0d", c), out4, (c == 3 || c == 7) ? E_DONE : E_MDSTL);
      check($sformatf("b2b_l1_c%0d", c), out1, E_DONE);
    end
    next_cycle(); clear_inputs(); #1;
    check("b2b_c8_idle", out4, E_NONE);

    // Asynchronous reset in cycle 1 of an operation.
    next_cycle(); clear_inputs(); MdStartE = 1'b1; #1;
    check("rst_md_c0", out4, E_MDSTL);
    next_cycle(); MdStartE = 1'b0; RegWriteM = 1'b1; RdM = 5'd7; Rs1E = 5'd7; #1;
    check("rst_md_c1", out4, {6'b110101, 2'b10, 2'b00, 1'b0});
    #1 rst = 1'b1;
    #1;
    check("rst_async_drop", out4, E_NONE);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    for (int c = 0; c < 5; c++) begin
      next_cycle(); #1;
      check($sformatf("rst_after_c%0d", c), out4, E_NONE);
    end
    next_cycle(); PCSrcE = 1'b1; #1;
    check("rst_after_idle", out4, E_BR);

    // A fresh operation after reset counts the full latency.
    for (int c = 0; c < 4; c++) begin
      next_cycle(); clear_inputs(); MdStartE = (c == 0); #1;
      check($sformatf("post_rst_md_c%0d", c), out4, (c == 3) ? E_DONE : E_MDSTL);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
